// File: rtl/usb_hub_repeater_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : usb_hub_repeater_ctrl_if
//  Purpose  : Bundles the SOP/EOP pulses, port enables and repeater
//             direction outputs that pass between the line-state front ends,
//             the hub control logic and usb_hub_repeater_ctrl.
//  Modports : master - front ends / hub control (drive pulses and enables,
//                      observe direction controls)
//             slave  - usb_hub_repeater_ctrl (observe pulses and enables,
//                      drive direction controls)
//  Signals  : host_sop, host_eop      host-port packet delimiters (1 bit)
//             dev_sop, dev_eop        per-device-port delimiters (N bits)
//             port_enable             per-port enable level (N bits)
//             down_en                 broadcast drive enables (N bits)
//             up_sel, up_en           upstream port select / host drive
//             busy                    controller not idle
//             port_babble             sticky per-port babble flags (N bits)
//             babble_pulse            one-cycle babble indication
//  Revision : 1.0 - initial release
// ============================================================================
interface usb_hub_repeater_ctrl_if #(
    parameter int NUM_USB_DEVICES = 16
);
    logic                       host_sop;
    logic                       host_eop;
    logic [NUM_USB_DEVICES-1:0] dev_sop;
    logic [NUM_USB_DEVICES-1:0] dev_eop;
    logic [NUM_USB_DEVICES-1:0] port_enable;
    logic [NUM_USB_DEVICES-1:0] down_en;
    logic [NUM_USB_DEVICES-1:0] up_sel;
    logic                       up_en;
    logic                       busy;
    logic [NUM_USB_DEVICES-1:0] port_babble;
    logic                       babble_pulse;

    modport master (
        output host_sop, host_eop, dev_sop, dev_eop, port_enable,
        input  down_en, up_sel, up_en, busy, port_babble, babble_pulse
    );

    modport slave (
        input  host_sop, host_eop, dev_sop, dev_eop, port_enable,
        output down_en, up_sel, up_en, busy, port_babble, babble_pulse
    );
endinterface
`default_nettype wire

// File: rtl/usb_hub_repeater_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : usb_hub_repeater_ctrl
//  Purpose  : Per-packet direction control of the hub repeater. Either the
//             host broadcasts to every enabled, non-babbling device port, or
//             one device port (granted round-robin) drives the host. Packets
//             that outlive MAX_PKT_CYCLES are cut off as babble; an upstream
//             babbler is flagged and locked out until its enable drops.
//  Ports    : hi_clock  - sole clock, rising edge
//             reset     - synchronous, active-high
//             bus       - usb_hub_repeater_ctrl_if.slave (pulses in,
//                         registered direction controls out)
//  Revision : 1.0 - initial release
// ============================================================================
module usb_hub_repeater_ctrl #(
    parameter int NUM_USB_DEVICES = 16,
    parameter int MAX_PKT_CYCLES  = 1023,
    parameter int GAP_CYCLES      = 4
) (
    input wire                     hi_clock,
    input wire                     reset,
    usb_hub_repeater_ctrl_if.slave bus
);
    localparam int c_n       = NUM_USB_DEVICES;
    localparam int c_cnt_top = (MAX_PKT_CYCLES > GAP_CYCLES) ? MAX_PKT_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_top + 1);
    localparam int c_lg_w    = $clog2(c_n);

    localparam logic [c_cnt_w-1:0] c_pkt_lim = c_cnt_w'(MAX_PKT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_gap_lim = c_cnt_w'(GAP_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(c_cnt_top);
    localparam logic [c_lg_w-1:0]  c_lg_rst  = c_lg_w'(c_n - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_down = 2'd1;
    localparam logic [1:0] c_st_up   = 2'd2;
    localparam logic [1:0] c_st_gap  = 2'd3;

    logic [1:0]         r_state,        w_state_nx;
    logic [c_cnt_w-1:0] r_cnt,          w_cnt_nx;
    logic [c_lg_w-1:0]  r_last_grant,   w_lg_nx;
    // A timeout is decided on the state transition but reported one edge
    // later, so the babble indications line up with the enables dropping.
    logic               r_to_pend,      w_to_pend_nx;
    logic               r_to_up,        w_to_up_nx;

    logic [c_n-1:0]     r_down_en,      w_down_en_nx;
    logic [c_n-1:0]     r_up_sel,       w_up_sel_nx;
    logic               r_up_en,        w_up_en_nx;
    logic               r_busy,         w_busy_nx;
    logic [c_n-1:0]     r_port_babble,  w_port_babble_nx;
    logic               r_babble_pulse, w_babble_nx;

    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [c_n-1:0]     w_req;
    logic [c_n-1:0]     w_grant_oh;
    logic               w_found;
    logic [c_lg_w-1:0]  w_pick;
    logic [c_lg_w-1:0]  w_idx;
    int                 w_sum;

    assign w_cnt_inc  = (r_cnt == c_cnt_sat) ? r_cnt : r_cnt + 1'b1;
    assign w_req      = bus.dev_sop & bus.port_enable & ~r_port_babble;
    assign w_grant_oh = {{(c_n-1){1'b0}}, 1'b1} << r_last_grant;

    // Round-robin search: first requester at or after last_grant+1, mod N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        w_idx   = '0;
        w_sum   = 0;
        for (int i = 0; i < c_n; i++) begin
            w_sum = (int'(r_last_grant) + 1 + i) % c_n;
            w_idx = c_lg_w'(w_sum);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_lg_nx      = r_last_grant;
        w_to_pend_nx = 1'b0;
        w_to_up_nx   = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_cnt_nx = '0;
                if (bus.host_sop) begin
                    w_state_nx = c_st_down;
                end else if (w_found) begin
                    w_state_nx = c_st_up;
                    w_lg_nx    = w_pick;
                end
            end
            c_st_down: begin
                if (bus.host_eop) begin
                    w_state_nx = c_st_gap;
                    w_cnt_nx   = '0;
                end else if (w_cnt_inc == c_pkt_lim) begin
                    w_state_nx   = c_st_gap;
                    w_cnt_nx     = '0;
                    w_to_pend_nx = 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            c_st_up: begin
                // A regular EOP or the port being disabled both end the
                // packet cleanly; neither counts as babble.
                if (bus.dev_eop[r_last_grant] || !bus.port_enable[r_last_grant]) begin
                    w_state_nx = c_st_gap;
                    w_cnt_nx   = '0;
                end else if (w_cnt_inc == c_pkt_lim) begin
                    w_state_nx   = c_st_gap;
                    w_cnt_nx     = '0;
                    w_to_pend_nx = 1'b1;
                    w_to_up_nx   = 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            c_st_gap: begin
                if (w_cnt_inc >= c_gap_lim) begin
                    w_state_nx = c_st_idle;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: begin
                w_state_nx = c_st_idle;
                w_cnt_nx   = '0;
            end
        endcase

        w_down_en_nx     = (r_state == c_st_down) ? (bus.port_enable & ~r_port_babble) : '0;
        w_up_en_nx       = (r_state == c_st_up);
        w_up_sel_nx      = (r_state == c_st_up) ? w_grant_oh : '0;
        w_busy_nx        = (r_state != c_st_idle);
        w_babble_nx      = r_to_pend;
        // Set wins over the enable-low clear.
        w_port_babble_nx = (r_port_babble & bus.port_enable) | (r_to_up ? w_grant_oh : '0);
    end

    always_ff @(posedge hi_clock) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_cnt          <= '0;
            r_last_grant   <= c_lg_rst;
            r_to_pend      <= 1'b0;
            r_to_up        <= 1'b0;
            r_down_en      <= '0;
            r_up_sel       <= '0;
            r_up_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_port_babble  <= '0;
            r_babble_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_cnt          <= w_cnt_nx;
            r_last_grant   <= w_lg_nx;
            r_to_pend      <= w_to_pend_nx;
            r_to_up        <= w_to_up_nx;
            r_down_en      <= w_down_en_nx;
            r_up_sel       <= w_up_sel_nx;
            r_up_en        <= w_up_en_nx;
            r_busy         <= w_busy_nx;
            r_port_babble  <= w_port_babble_nx;
            r_babble_pulse <= w_babble_nx;
        end
    end

    assign bus.down_en      = r_down_en;
    assign bus.up_sel       = r_up_sel;
    assign bus.up_en        = r_up_en;
    assign bus.busy         = r_busy;
    assign bus.port_babble  = r_port_babble;
    assign bus.babble_pulse = r_babble_pulse;
endmodule
`default_nettype wire

// File: tb/tb_usb_hub_repeater_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_hub_repeater_ctrl
//  Purpose  : Scoreboard bench for usb_hub_repeater_ctrl. Stimulus tasks issue
//             packets and push the expected packet-level response (direction,
//             port/mask, visible length, gap, babble); a monitor pops one entry
//             per busy period and checks the outputs cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_hub_repeater_ctrl;
    localparam int N    = 16;
    localparam int MAXP = 1023;
    localparam int GAP  = 4;
    localparam int LW   = $clog2(N);

    typedef struct {
        bit           is_up;
        logic [N-1:0] mask;
        int           port;
        int           len;
        int           gap;
        bit           bab;
        logic [N-1:0] pb;
    } exp_t;

    logic hi_clock = 1'b0;
    logic reset    = 1'b1;

    usb_hub_repeater_ctrl_if #(.NUM_USB_DEVICES(N)) bus ();

    usb_hub_repeater_ctrl #(
        .NUM_USB_DEVICES(N),
        .MAX_PKT_CYCLES (MAXP),
        .GAP_CYCLES     (GAP)
    ) dut (
        .hi_clock(hi_clock),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 hi_clock = ~hi_clock;

    int           n_cmp = 0;
    int           n_mis = 0;
    exp_t         sb[$];
    logic [N-1:0] m_en;
    logic [N-1:0] m_bab;
    int           m_last;
    bit           mon_on = 1'b0;

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p[LW-1:0]] = 1'b1;
        return v;
    endfunction

    // Reference arbitration: scan ports last+1, last+2, ... (mod N).
    function automatic int rr_pick(input logic [N-1:0] elig);
        for (int i = 1; i <= N; i++) begin
            int p;
            p = (m_last + i) % N;
            if (elig[p[LW-1:0]]) return p;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge hi_clock);
        #1;
    endtask

    task automatic set_en(input logic [N-1:0] e);
        bus.port_enable = e;
        m_en  = e;
        m_bab = m_bab & e;
    endtask

    // Host packet: SOP, EOP len cycles later; optional device SOP in the same
    // cycle as the host SOP and optional device SOP inside the gap.
    task automatic host_pkt(input int len, input logic [N-1:0] co_dev, input bit gap_drop);
        exp_t e;
        e.is_up = 1'b0; e.mask = m_en & ~m_bab; e.port = 0;
        e.len = len; e.gap = GAP; e.bab = 1'b0; e.pb = m_bab;
        sb.push_back(e);
        bus.host_sop = 1'b1; bus.dev_sop = co_dev;
        tick();
        bus.host_sop = 1'b0; bus.dev_sop = '0;
        repeat (len - 1) tick();
        bus.host_eop = 1'b1;
        tick();
        bus.host_eop = 1'b0;
        if (gap_drop) begin
            tick();
            bus.dev_sop = oh(1);
            tick();
            bus.dev_sop = '0;
        end
        repeat (GAP + 3) tick();
    endtask

    // Device request. mode 0: EOP after len; 1: babble; 2: enable drop after len.
    task automatic dev_pkt(input logic [N-1:0] req, input int len, input int mode);
        logic [N-1:0] elig;
        logic [N-1:0] goh;
        int           g;
        exp_t         e;
        elig = req & m_en & ~m_bab;
        if (elig == '0) begin
            bus.dev_sop = req;
            tick();
            bus.dev_sop = '0;
            repeat (3) tick();
            return;
        end
        g      = rr_pick(elig);
        m_last = g;
        goh    = oh(g);
        if (mode == 1) m_bab = m_bab | goh;
        e.is_up = 1'b1; e.mask = '0; e.port = g; e.gap = GAP;
        e.bab = (mode == 1); e.len = (mode == 1) ? MAXP : len; e.pb = m_bab;
        sb.push_back(e);
        bus.dev_sop = req;
        tick();
        bus.dev_sop = '0;
        if (mode == 1) begin
            repeat (MAXP + GAP + 3) tick();
        end else begin
            for (int t = 1; t < len; t++) begin
                if (len >= 4 && t == len / 2) bus.host_sop = 1'b1;
                if (t == 1) bus.dev_eop = N'($urandom) & ~goh;
                tick();
                bus.host_sop = 1'b0;
                bus.dev_eop  = '0;
            end
            if (mode == 0) begin
                bus.dev_eop = goh | (N'($urandom) & ~goh);
                tick();
                bus.dev_eop = '0;
            end else begin
                bus.port_enable = m_en & ~goh;
                tick();
                bus.port_enable = m_en;
            end
            repeat (GAP + 3) tick();
        end
    endtask

    // Host packet interrupted by reset r cycles after the SOP edge.
    task automatic host_reset(input int r);
        exp_t e;
        e.is_up = 1'b0; e.mask = m_en & ~m_bab; e.port = 0;
        e.len = r - 1; e.gap = 0; e.bab = 1'b0; e.pb = '0;
        sb.push_back(e);
        bus.host_sop = 1'b1;
        tick();
        bus.host_sop = 1'b0;
        repeat (r - 1) tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_last = N - 1;
        m_bab  = '0;
        repeat (3) tick();
    endtask

    // Monitor: one scoreboard entry per busy period, checked cycle by cycle.
    initial begin
        bit           active;
        bit           skip;
        int           i;
        exp_t         cur;
        logic [63:0]  act;
        logic [63:0]  want;
        bit           inpkt;
        bit           up_e;
        logic [N-1:0] down_e;
        logic [N-1:0] sel_e;
        active = 1'b0;
        skip   = 1'b0;
        i      = 0;
        wait (mon_on);
        forever begin
            @(negedge hi_clock);
            if (skip) begin
                if (!bus.busy) skip = 1'b0;
            end else if (!active && bus.busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_packet", 64'(bus.busy), 64'd0);
                    skip = 1'b1;
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    i      = 0;
                end
            end
            if (active) begin
                inpkt  = (i < cur.len);
                up_e   = cur.is_up && inpkt;
                down_e = (!cur.is_up && inpkt) ? cur.mask : '0;
                sel_e  = up_e ? oh(cur.port) : '0;
                want = 64'({(i < cur.len + cur.gap), down_e, sel_e, up_e, (cur.bab && i == cur.len)});
                act  = 64'({bus.busy, bus.down_en, bus.up_sel, bus.up_en, bus.babble_pulse});
                check($sformatf("pkt_cycle%0d", i), act, want);
                i++;
                if (i > cur.len + cur.gap) begin
                    check("port_babble", 64'(bus.port_babble), 64'(cur.pb));
                    active = 1'b0;
                end
            end else if (!skip) begin
                check("idle_outputs", 64'({bus.down_en, bus.up_sel, bus.up_en, bus.babble_pulse}), 64'd0);
            end
        end
    end

    initial begin
        bus.host_sop = 1'b0; bus.host_eop = 1'b0;
        bus.dev_sop = '0; bus.dev_eop = '0; bus.port_enable = '0;
        m_en = '0; m_bab = '0; m_last = N - 1;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_down_en",      64'(bus.down_en),      64'd0);
        check("rst_up_sel",       64'(bus.up_sel),       64'd0);
        check("rst_up_en",        64'(bus.up_en),        64'd0);
        check("rst_busy",         64'(bus.busy),         64'd0);
        check("rst_port_babble",  64'(bus.port_babble),  64'd0);
        check("rst_babble_pulse", 64'(bus.babble_pulse), 64'd0);
        reset = 1'b0;
        mon_on = 1'b1;
        tick();

        set_en(16'h00FF);
        tick();
        host_pkt(10, '0, 1'b0);

        set_en(16'hFFFF);
        tick();
        host_pkt(5, 16'h0008, 1'b0);
        dev_pkt(16'h0009, 6, 0);
        dev_pkt(16'h0009, 3, 0);
        dev_pkt(16'h0009, 1, 0);
        dev_pkt(16'h8000, 4, 0);
        dev_pkt(16'h8001, 2, 0);

        dev_pkt(16'h0020, 0, 1);
        dev_pkt(16'h0020, 3, 0);
        set_en(16'hFFDF);
        tick();
        set_en(16'hFFFF);
        tick();
        dev_pkt(16'h0020, 4, 0);

        dev_pkt(16'h0004, 6, 2);
        host_reset(5);
        dev_pkt(16'h0009, 3, 0);
        host_pkt(3, '0, 1'b1);

        for (int it = 0; it < 60; it++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 30);
            if (sel < 3)       host_pkt(len, N'($urandom), 1'b0);
            else if (sel < 6)  dev_pkt(N'($urandom), len, 0);
            else if (sel < 8)  dev_pkt(N'($urandom) & N'($urandom), len, 0);
            else if (sel == 8) dev_pkt(N'($urandom), len, 2);
            else begin
                set_en(N'($urandom) | N'(1));
                tick();
            end
        end

        repeat (10) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
